hazard_unit_mc: RTL and testbench

Parametrised hazard unit for the 5-stage RISC-V pipeline with a sequential multi-cycle (MUL/DIV) occupancy tracker. It replaces the delayed `start_*_E_n` flag chains with an internal countdown FSM, so MUL and DIV latency are set by parameters rather than by external shift registers. It also inserts a proper load-use bubble and can optionally count stall and flush cycles. It sits beside the datapath and drives stall, flush and forward controls for all stages.

---
 rtl/hazard_unit_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc
//   Hazard unit for the 5-stage RISC-V pipeline. It provides:
//   - operand forwarding selects for the execute stage (M and W sources),
//   - a load-use bubble (stall F/D, flush E),
//   - a multi-cycle MUL/DIV occupancy tracker. A countdown FSM holds F/D/E and
//     flushes M while a MUL or DIV is still computing, so latency is set by
//     the MUL_LAT / DIV_LAT parameters,
//   - optional stall/flush performance counters, built only when the macro
//     HAZARD_PERF_CNT_EN is defined. Otherwise the counters read as zero and
//     cnt_clr has no effect.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   rs1_D, rs2_D              decode-stage source registers
//   rs1_E, rs2_E, rd_E        execute-stage registers
//   rd_M, rd_W                memory / writeback destination registers
//   RegWrite_M, RegWrite_W    write enables in M and W
//   ResultSrc_E               result select in E (01 = load)
//   PCSrc_E                   taken branch/jump resolved in E
//   start_mult_E, start_div_E first-cycle pulse of a MUL / DIV in E
//   ForwardA_E, ForwardB_E    10 = from M, 01 = from W, 00 = register file
//   Stall_F, Stall_D, Stall_E hold pipeline registers
//   Flush_D, Flush_E, Flush_M clear pipeline registers
//   md_busy                   multi-cycle unit is in a BUSY state
//   lw_stall_cnt, md_stall_cnt, flush_cnt  performance counters
//   cnt_clr                   synchronous clear of the performance counters
// -----------------------------------------------------------------------------
module hazard_unit_mc #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int RESULTSRC_WIDTH = 2,
    parameter int MUL_LAT         = 3,
    parameter int DIV_LAT         = 8,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_D,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_D,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_E,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_E,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_E,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_M,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_W,
    input  logic                       RegWrite_M,
    input  logic                       RegWrite_W,
    input  logic [RESULTSRC_WIDTH-1:0] ResultSrc_E,
    input  logic                       PCSrc_E,
    input  logic                       start_mult_E,
    input  logic                       start_div_E,
    output logic [1:0]                 ForwardA_E,
    output logic [1:0]                 ForwardB_E,
    output logic                       Stall_F,
    output logic                       Stall_D,
    output logic                       Stall_E,
    output logic                       Flush_D,
    output logic                       Flush_E,
    output logic                       Flush_M,
    output logic                       md_busy,
    output logic [CNT_WIDTH-1:0]       lw_stall_cnt,
    output logic [CNT_WIDTH-1:0]       md_stall_cnt,
    output logic [CNT_WIDTH-1:0]       flush_cnt,
    input  logic                       cnt_clr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_BUSY_MUL = 2'b01,
        ST_BUSY_DIV = 2'b10
    } md_state_t;

    localparam logic [REG_ADDR_WIDTH-1:0]  REG_ZERO   = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [RESULTSRC_WIDTH-1:0] RS_LOAD    = {{(RESULTSRC_WIDTH-1){1'b0}}, 1'b1};
    // A latency of 1 never occupies E for extra cycles, so it never starts the FSM.
    localparam logic                       MUL_MULTI  = (MUL_LAT > 1) ? 1'b1 : 1'b0;
    localparam logic                       DIV_MULTI  = (DIV_LAT > 1) ? 1'b1 : 1'b0;
    localparam logic [7:0]                 MUL_LAT_M1 = 8'(MUL_LAT - 1);
    localparam logic [7:0]                 DIV_LAT_M1 = 8'(DIV_LAT - 1);

    md_state_t  state_r;
    logic [7:0] cnt_r;
    logic       lw_stall_s;
    logic       md_stall_s;
    logic       mul_go_s;
    logic       div_go_s;

    // Forward select for one operand: M has priority over W, x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      we_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_w
    );
        logic [1:0] sel;
        if ((rs != REG_ZERO) && we_m && (rs == rd_m)) begin
            sel = 2'b10;
        end else if ((rs != REG_ZERO) && we_w && (rs == rd_w)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding for both execute-stage sources.
    always_comb begin
        ForwardA_E = fwd_sel(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W);
        ForwardB_E = fwd_sel(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W);
    end

    // Load-use detection: a load in E feeding either decode-stage source.
    always_comb begin
        lw_stall_s = (ResultSrc_E == RS_LOAD) && (rd_E != REG_ZERO) &&
                     ((rs1_D == rd_E) || (rs2_D == rd_E));
    end

    // Start acceptance and multi-cycle stall; starts only count while IDLE, MUL beats DIV.
    always_comb begin
        mul_go_s   = 1'b0;
        div_go_s   = 1'b0;
        md_stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mul_go_s   = start_mult_E & MUL_MULTI;
                div_go_s   = start_div_E & ~start_mult_E & DIV_MULTI;
                md_stall_s = mul_go_s | div_go_s;
            end
            ST_BUSY_MUL, ST_BUSY_DIV: begin
                // The last occupied cycle (cnt == 1) releases the pipeline.
                md_stall_s = (cnt_r > 8'd1);
            end
            default: begin
                md_stall_s = 1'b0;
            end
        endcase
    end

    // Countdown FSM tracking how long the current MUL/DIV still occupies E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mul_go_s) begin
                        state_r <= ST_BUSY_MUL;
                        cnt_r   <= MUL_LAT_M1;
                    end else if (div_go_s) begin
                        state_r <= ST_BUSY_DIV;
                        cnt_r   <= DIV_LAT_M1;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= cnt_r;
                    end
                end
                ST_BUSY_MUL, ST_BUSY_DIV: begin
                    cnt_r <= cnt_r - 8'd1;
                    // <= rather than == so a corrupted zero count cannot lock the FSM.
                    if (cnt_r <= 8'd1) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    // Combined pipeline controls; a held E stage is never flushed by a load-use.
    always_comb begin
        Stall_F = lw_stall_s | md_stall_s;
        Stall_D = lw_stall_s | md_stall_s;
        Stall_E = md_stall_s;
        Flush_D = PCSrc_E;
        Flush_E = PCSrc_E | (lw_stall_s & ~md_stall_s);
        Flush_M = md_stall_s;
        md_busy = (state_r != ST_IDLE);
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] lw_cnt_r;
    logic [CNT_WIDTH-1:0] md_cnt_r;
    logic [CNT_WIDTH-1:0] fl_cnt_r;

    // Saturating event counters; cnt_clr wins over any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lw_cnt_r <= {CNT_WIDTH{1'b0}};
            md_cnt_r <= {CNT_WIDTH{1'b0}};
            fl_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_clr) begin
            lw_cnt_r <= {CNT_WIDTH{1'b0}};
            md_cnt_r <= {CNT_WIDTH{1'b0}};
            fl_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (lw_stall_s && !md_stall_s && (lw_cnt_r != CNT_MAX)) begin
                lw_cnt_r <= lw_cnt_r + CNT_ONE;
            end
            if (md_stall_s && (md_cnt_r != CNT_MAX)) begin
                md_cnt_r <= md_cnt_r + CNT_ONE;
            end
            if (PCSrc_E && (fl_cnt_r != CNT_MAX)) begin
                fl_cnt_r <= fl_cnt_r + CNT_ONE;
            end
        end
    end

    assign lw_stall_cnt = lw_cnt_r;
    assign md_stall_cnt = md_cnt_r;
    assign flush_cnt    = fl_cnt_r;
`else
    // Counters not built: outputs read as zero and the clear input is a no-op.
    logic unused_cnt_clr_s;
    assign unused_cnt_clr_s = cnt_clr;
    assign lw_stall_cnt     = {CNT_WIDTH{1'b0}};
    assign md_stall_cnt     = {CNT_WIDTH{1'b0}};
    assign flush_cnt        = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_mc
//   Self-checking bench for hazard_unit_mc. A cycle-numbered reference model
//   describes each accepted MUL/DIV as an occupancy window [start, start+LAT-1].
//   Directed scenarios are followed by randomized traffic; every cycle all
//   outputs are compared with the model.
// -----------------------------------------------------------------------------
module tb_hazard_unit_mc;

    localparam int RW  = 5;
    localparam int RSW = 2;
    localparam int ML  = 3;
    localparam int DL  = 8;
    localparam int CW  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [RW-1:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic           RegWrite_M, RegWrite_W;
    logic [RSW-1:0] ResultSrc_E;
    logic           PCSrc_E, start_mult_E, start_div_E, cnt_clr;
    logic [1:0]     ForwardA_E, ForwardB_E;
    logic           Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, md_busy;
    logic [CW-1:0]  lw_stall_cnt, md_stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_ADDR_WIDTH(RW), .RESULTSRC_WIDTH(RSW), .MUL_LAT(ML), .DIV_LAT(DL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .rd_M(rd_M), .rd_W(rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
        .start_mult_E(start_mult_E), .start_div_E(start_div_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
        .md_busy(md_busy),
        .lw_stall_cnt(lw_stall_cnt), .md_stall_cnt(md_stall_cnt), .flush_cnt(flush_cnt),
        .cnt_clr(cnt_clr)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    // Reference model: cycle index and occupancy window of the last accepted op.
    int     cyc       = 1;
    int     occ_start = 0;
    int     occ_end   = 0;
    longint m_lw = 0, m_md = 0, m_fl = 0;

    // Count one comparison and report it if the observed value differs.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
        if (rs != 0 && RegWrite_M && rs == rd_M) return 2'b10;
        if (rs != 0 && RegWrite_W && rs == rd_W) return 2'b01;
        return 2'b00;
    endfunction

    // The unit is busy in every cycle of the window except the accepting one.
    function automatic bit ref_busy();
        return (occ_start < cyc) && (cyc <= occ_end);
    endfunction

    task automatic model_reset();
        occ_start = 0;
        occ_end   = 0;
        m_lw = 0; m_md = 0; m_fl = 0;
    endtask

    task automatic clr_inputs();
        rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
        RegWrite_M = 1'b0; RegWrite_W = 1'b0; ResultSrc_E = '0; PCSrc_E = 1'b0;
        start_mult_E = 1'b0; start_div_E = 1'b0; cnt_clr = 1'b0;
    endtask

    // Check all outputs for the inputs driven at this negedge, then advance one clock.
    task automatic step();
        bit     lw, busy, starting, stall;
        int     lat;
        longint e_lw, e_md, e_fl;
        #1;
        if (rst) model_reset();
        busy = ref_busy();
        lat  = 0;
        if (!busy) begin
            if (start_mult_E)     lat = ML;
            else if (start_div_E) lat = DL;
        end
        starting = (lat > 1);
        stall = ((occ_start < cyc) && (cyc < occ_end)) || starting;
        lw    = (ResultSrc_E == 2'b01) && (rd_E != 0) && (rs1_D == rd_E || rs2_D == rd_E);
`ifdef HAZARD_PERF_CNT_EN
        e_lw = m_lw; e_md = m_md; e_fl = m_fl;
`else
        e_lw = 0; e_md = 0; e_fl = 0;
`endif
        check_val("fwd_a",   64'(ForwardA_E), 64'(ref_fwd(rs1_E)));
        check_val("fwd_b",   64'(ForwardB_E), 64'(ref_fwd(rs2_E)));
        check_val("stall_f", 64'(Stall_F), 64'(lw | stall));
        check_val("stall_d", 64'(Stall_D), 64'(lw | stall));
        check_val("stall_e", 64'(Stall_E), 64'(stall));
        check_val("flush_d", 64'(Flush_D), 64'(PCSrc_E));
        check_val("flush_e", 64'(Flush_E), 64'(PCSrc_E | (lw & ~stall)));
        check_val("flush_m", 64'(Flush_M), 64'(stall));
        check_val("md_busy", 64'(md_busy), 64'(busy));
        check_val("lw_cnt",  64'(lw_stall_cnt), 64'(e_lw));
        check_val("md_cnt",  64'(md_stall_cnt), 64'(e_md));
        check_val("fl_cnt",  64'(flush_cnt),    64'(e_fl));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (starting) begin
                occ_start = cyc;
                occ_end   = cyc + lat - 1;
            end
            if (cnt_clr) begin
                m_lw = 0; m_md = 0; m_fl = 0;
            end else begin
                if (lw && !stall) m_lw++;
                if (stall)        m_md++;
                if (PCSrc_E)      m_fl++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        @(negedge clk);
        step();
        rst = 1'b0;
        step();

        // Forwarding: M beats W; a W-only match; register x0 never forwards.
        rs1_E = 5'd5; rd_M = 5'd5; RegWrite_M = 1'b1; rs2_E = 5'd5; rd_W = 5'd5; RegWrite_W = 1'b1;
        step();
        rs2_E = 5'd6; rd_W = 5'd6;
        step();
        rs1_E = 5'd0; rs2_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0;
        step();
        clr_inputs();

        // Load-use with rd_E = 7, then the x0 destination that must not stall.
        ResultSrc_E = 2'b01; rd_E = 5'd7; rs2_D = 5'd7;
        step();
        clr_inputs();
        step();
        ResultSrc_E = 2'b01; rd_E = 5'd0; rs2_D = 5'd0;
        step();
        clr_inputs();

        // MUL: single pulse, then let the window drain.
        start_mult_E = 1'b1;
        step();
        start_mult_E = 1'b0;
        repeat (3) step();

        // DIV with a second pulse at t+3 that must be ignored.
        start_div_E = 1'b1;
        step();
        start_div_E = 1'b0;
        repeat (2) step();
        start_div_E = 1'b1;
        step();
        start_div_E = 1'b0;
        repeat (6) step();

        // Simultaneous starts (MUL wins), then asynchronous reset mid-busy.
        start_mult_E = 1'b1; start_div_E = 1'b1;
        step();
        start_mult_E = 1'b0; start_div_E = 1'b0;
        #2;
        check_val("busy_before_rst", 64'(md_busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Three taken branches then a counter clear.
        PCSrc_E = 1'b1;
        repeat (3) step();
        PCSrc_E = 1'b0;
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();

        // Randomized traffic on a small register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            rs1_D = RW'($urandom_range(0, 3)); rs2_D = RW'($urandom_range(0, 3));
            rs1_E = RW'($urandom_range(0, 3)); rs2_E = RW'($urandom_range(0, 3));
            rd_E  = RW'($urandom_range(0, 3)); rd_M  = RW'($urandom_range(0, 3));
            rd_W  = RW'($urandom_range(0, 3));
            RegWrite_M   = 1'($urandom_range(0, 1));
            RegWrite_W   = 1'($urandom_range(0, 1));
            ResultSrc_E  = RSW'($urandom_range(0, 3));
            PCSrc_E      = ($urandom_range(0, 7) == 0);
            start_mult_E = ($urandom_range(0, 5) == 0);
            start_div_E  = ($urandom_range(0, 5) == 0);
            // A pipeline never issues a new MUL/DIV on the final occupied cycle.
            if (ref_busy() && cyc == occ_end) begin
                start_mult_E = 1'b0;
                start_div_E  = 1'b0;
            end
            cnt_clr = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        clr_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
